// File: rtl/alu_z_stage.sv
// alu_z_stage: result-capture stage behind the datapath ALU units.
// Waits a per-class settle count after a start request, then captures the
// selected unit's output into the 64-bit Z register with C/Z/N flags and
// pulses done for one cycle. All outputs are registered.
module alu_z_stage #(
  parameter int unsigned LOGIC_CYCLES  = 1,
  parameter int unsigned ADDSUB_CYCLES = 1,
  parameter int unsigned MUL_CYCLES    = 4,
  parameter int unsigned DIV_CYCLES    = 8
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [1:0]  op_class,
  input  logic [31:0] logic_result,
  input  logic        logic_carry,
  input  logic        logic_zero,
  input  logic [31:0] addsub_result,
  input  logic        addsub_carry,
  input  logic        addsub_zero,
  input  logic [63:0] mul_product,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic [31:0] div_b,
  output logic [63:0] z_out,
  output logic        flag_c,
  output logic        flag_z,
  output logic        flag_n,
  output logic        div_by_zero,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [1:0] OP_LOGIC  = 2'b00;
  localparam logic [1:0] OP_ADDSUB = 2'b01;
  localparam logic [1:0] OP_MUL    = 2'b10;
  localparam logic [1:0] OP_DIV    = 2'b11;

  // Counter preload is N-1; a zero parameter behaves as a single settle cycle.
  localparam logic [3:0] LOGIC_LOAD  = (LOGIC_CYCLES  == 0) ? 4'd0 : 4'(LOGIC_CYCLES  - 1);
  localparam logic [3:0] ADDSUB_LOAD = (ADDSUB_CYCLES == 0) ? 4'd0 : 4'(ADDSUB_CYCLES - 1);
  localparam logic [3:0] MUL_LOAD    = (MUL_CYCLES    == 0) ? 4'd0 : 4'(MUL_CYCLES    - 1);
  localparam logic [3:0] DIV_LOAD    = (DIV_CYCLES    == 0) ? 4'd0 : 4'(DIV_CYCLES    - 1);

  logic [1:0]  state;
  logic [1:0]  op_q;
  logic [3:0]  cnt;
  logic [3:0]  load_val;
  logic [63:0] cap_z;
  logic        cap_c;
  logic        cap_zf;
  logic        cap_n;

  // Settle-count preload for the class being accepted (live op_class).
  always_comb begin
    load_val = LOGIC_LOAD;
    case (op_class)
      OP_LOGIC:  load_val = LOGIC_LOAD;
      OP_ADDSUB: load_val = ADDSUB_LOAD;
      OP_MUL:    load_val = MUL_LOAD;
      OP_DIV:    load_val = DIV_LOAD;
      default:   load_val = LOGIC_LOAD;
    endcase
  end

  // Capture value and flags selected by the latched class.
  always_comb begin
    cap_z  = '0;
    cap_c  = 1'b0;
    cap_zf = 1'b0;
    cap_n  = 1'b0;
    case (op_q)
      OP_LOGIC: begin
        cap_z  = {32'd0, logic_result};
        cap_c  = logic_carry;
        cap_zf = logic_zero;
        cap_n  = logic_result[31];
      end
      OP_ADDSUB: begin
        cap_z  = {32'd0, addsub_result};
        cap_c  = addsub_carry;
        cap_zf = addsub_zero;
        cap_n  = addsub_result[31];
      end
      OP_MUL: begin
        cap_z  = mul_product;
        cap_zf = (mul_product == '0);
        cap_n  = mul_product[63];
      end
      OP_DIV: begin
        cap_z  = {div_remainder, div_quotient};
        cap_zf = (div_quotient == '0);
        cap_n  = div_quotient[31];
      end
      default: cap_z = '0;
    endcase
  end

  // Control FSM, settle counter and registered Z/flag outputs.
  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      op_q        <= OP_LOGIC;
      cnt         <= '0;
      z_out       <= '0;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= op_class;
            cnt   <= load_val;
            busy  <= 1'b1;
            state <= SETTLE;
          end else begin
            state <= IDLE;
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            z_out  <= cap_z;
            flag_c <= cap_c;
            flag_z <= cap_zf;
            flag_n <= cap_n;
            if (op_q == OP_DIV && div_b == '0) div_by_zero <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_z_stage.sv
// tb_alu_z_stage: directed and randomized checks of alu_z_stage against a
// transaction-level model (accept edge + N edges -> capture).
module tb_alu_z_stage;

  localparam int LC = 1;
  localparam int AC = 1;
  localparam int MC = 4;
  localparam int DC = 8;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op_class = 2'b00;
  logic [31:0] logic_result = '0;
  logic        logic_carry = 1'b0;
  logic        logic_zero = 1'b0;
  logic [31:0] addsub_result = '0;
  logic        addsub_carry = 1'b0;
  logic        addsub_zero = 1'b0;
  logic [63:0] mul_product = '0;
  logic [31:0] div_quotient = '0;
  logic [31:0] div_remainder = '0;
  logic [31:0] div_b = '0;
  logic [63:0] z_out;
  logic        flag_c, flag_z, flag_n, div_by_zero, busy, done;

  alu_z_stage #(
    .LOGIC_CYCLES (LC),
    .ADDSUB_CYCLES(AC),
    .MUL_CYCLES   (MC),
    .DIV_CYCLES   (DC)
  ) dut (
    .clock(clock), .clear(clear), .start(start), .op_class(op_class),
    .logic_result(logic_result), .logic_carry(logic_carry), .logic_zero(logic_zero),
    .addsub_result(addsub_result), .addsub_carry(addsub_carry), .addsub_zero(addsub_zero),
    .mul_product(mul_product), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_b(div_b),
    .z_out(z_out), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
    .div_by_zero(div_by_zero), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: an operation is pending for 'remain' more edges.
  logic [63:0] m_z;
  logic        m_c, m_zf, m_n, m_dbz, m_busy, m_done;
  bit          pending;
  int          remain;
  logic [1:0]  m_cls;

  function automatic int n_of(input logic [1:0] c);
    int p;
    case (c)
      2'b00:   p = LC;
      2'b01:   p = AC;
      2'b10:   p = MC;
      default: p = DC;
    endcase
    return (p == 0) ? 1 : p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    if (clear) begin
      m_z = '0; m_c = 0; m_zf = 0; m_n = 0; m_dbz = 0; m_busy = 0; m_done = 0;
      pending = 0; remain = 0;
    end else if (pending) begin
      remain--;
      m_done = 0;
      if (remain == 0) begin
        pending = 0; m_busy = 0; m_done = 1;
        case (m_cls)
          2'b00: begin
            m_z = {32'd0, logic_result}; m_c = logic_carry; m_zf = logic_zero;
            m_n = logic_result[31];
          end
          2'b01: begin
            m_z = {32'd0, addsub_result}; m_c = addsub_carry; m_zf = addsub_zero;
            m_n = addsub_result[31];
          end
          2'b10: begin
            m_z = mul_product; m_c = 0; m_zf = (mul_product == 0);
            m_n = mul_product[63];
          end
          default: begin
            m_z = {div_remainder, div_quotient}; m_c = 0; m_zf = (div_quotient == 0);
            m_n = div_quotient[31];
            if (div_b == 0) m_dbz = 1;
          end
        endcase
      end
    end else if (start) begin
      m_cls = op_class; remain = n_of(op_class); pending = 1;
      m_busy = 1; m_done = 0;
    end else begin
      m_done = 0;
    end
  endtask

  // One clock: edge, settle, step the model, compare every output.
  task automatic cyc();
    @(posedge clock);
    #1;
    model_edge();
    check("z_out", z_out, m_z);
    check("flag_c", 64'(flag_c), 64'(m_c));
    check("flag_z", 64'(flag_z), 64'(m_zf));
    check("flag_n", 64'(flag_n), 64'(m_n));
    check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    check("busy", 64'(busy), 64'(m_busy));
    check("done", 64'(done), 64'(m_done));
  endtask

  task automatic rand_inputs();
    logic_result  = $urandom; logic_carry  = 1'($urandom); logic_zero  = 1'($urandom);
    addsub_result = $urandom; addsub_carry = 1'($urandom); addsub_zero = 1'($urandom);
    mul_product   = {$urandom, $urandom};
    div_quotient  = $urandom; div_remainder = $urandom;
    div_b         = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
  endtask

  // Accept one op at the next edge, then count edges until done (bounded).
  task automatic launch(input logic [1:0] cls, input int limit, output int lat);
    start = 1'b1; op_class = cls;
    cyc();
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      cyc();
      if (done) begin lat = k; break; end
    end
  endtask

  initial begin
    int lat;
    int d1, d2, ndone;

    // Reset held two cycles with random inputs.
    clear = 1'b1; start = 1'b1;
    for (int i = 0; i < 2; i++) begin rand_inputs(); op_class = 2'($urandom); cyc(); end
    check("rst_z", z_out, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    clear = 1'b0; start = 1'b0;
    cyc();

    // Add/sub: zero result with carry.
    rand_inputs();
    addsub_result = 32'd0; addsub_carry = 1'b1; addsub_zero = 1'b1;
    launch(2'b01, 20, lat);
    check("addsub_lat", 64'(lat), 64'd1);
    check("addsub_z", z_out, 64'd0);
    check("addsub_flags", {61'd0, flag_c, flag_z, flag_n}, 64'b110);
    cyc();

    // Multiply -3*7; op_class and a start pulse change mid-settle.
    rand_inputs();
    mul_product = 64'hFFFF_FFFF_FFFF_FFEB;
    start = 1'b1; op_class = 2'b10;
    cyc();
    start = 1'b0; op_class = 2'b00;
    lat = -1; ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) start = 1'b1; else start = 1'b0;
      cyc();
      if (k < MC) check("mul_busy", 64'(busy), 64'd1);
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = k;
          check("mul_z", z_out, 64'hFFFF_FFFF_FFFF_FFEB);
          check("mul_nz", {62'd0, flag_n, flag_z}, 64'b10);
        end
      end
    end
    check("mul_lat", 64'(lat), 64'(MC));
    check("mul_single_done", 64'(ndone), 64'd1);

    // Divide 100/7, then divide by zero, then a logic op.
    rand_inputs();
    div_quotient = 32'd14; div_remainder = 32'd2; div_b = 32'd7;
    launch(2'b11, 20, lat);
    check("div_lat", 64'(lat), 64'(DC));
    check("div_z", z_out, 64'h0000_0002_0000_000E);
    check("div_dbz0", 64'(div_by_zero), 64'd0);
    div_b = 32'd0;
    launch(2'b11, 20, lat);
    check("div0_dbz", 64'(div_by_zero), 64'd1);
    rand_inputs();
    launch(2'b00, 20, lat);
    check("dbz_sticky", 64'(div_by_zero), 64'd1);
    check("logic_lat", 64'(lat), 64'd1);

    // Back-to-back: start held in the DONE cycle accepts a mul.
    rand_inputs();
    start = 1'b1; op_class = 2'b01;
    d1 = -1; d2 = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (done && d1 < 0) begin
        d1 = k; op_class = 2'b10;
      end else if (d1 >= 0 && !done) begin
        start = 1'b0;
      end
      if (done && d1 >= 0 && k != d1 && d2 < 0) d2 = k;
    end
    start = 1'b0;
    check("b2b_gap", 64'(d2 - d1), 64'(MC + 1));

    // Clear during the second settle cycle of a divide.
    cyc();
    rand_inputs(); div_b = 32'd5;
    start = 1'b1; op_class = 2'b11;
    cyc();
    start = 1'b0;
    cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_z", z_out, 64'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin cyc(); if (done) ndone++; end
    check("clr_no_done", 64'(ndone), 64'd0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      start    = ($urandom_range(0, 2) != 0);
      op_class = 2'($urandom);
      clear    = ($urandom_range(0, 63) == 0);
      cyc();
    end
    clear = 1'b0; start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_z_stage.md
# alu_z_stage

Result-capture stage directly downstream of the datapath ALU units (logic, add/sub, multiplier, divider). It accepts a start request from the control unit and waits a per-operation settle count so the deep combinational multiply/divide paths resolve. It then captures the selected unit's output into the 64-bit Z register ({ZHI, ZLO}) with condition flags and signals completion with a one-cycle `done` pulse. Downstream consumers (the bus, HI/LO, and condition-code logic) read only the registered Z and flag outputs.

## Interface
- `LOGIC_CYCLES`, default 1: settle cycles for logic ops (legal range 1–15; 0 is treated as 1).
- `ADDSUB_CYCLES`, default 1: settle cycles for add/sub (range 1–15).
- `MUL_CYCLES`, default 4: settle cycles for multiply (range 1–15).
- `DIV_CYCLES`, default 8: settle cycles for divide (range 1–15).

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `clear` in 1: reset, synchronous, active-high.
- `start` in 1: request; accepted only when `busy`=0.
- `op_class` in 2: 00 logic, 01 add/sub, 10 mul, 11 div; sampled only at acceptance.
- `logic_result` in 32, `logic_carry` in 1, `logic_zero` in 1: logic unit outputs.
- `addsub_result` in 32, `addsub_carry` in 1, `addsub_zero` in 1: adder outputs.
- `mul_product` in 64: signed product.
- `div_quotient` in 32, `div_remainder` in 32: divider outputs.
- `div_b` in 32: divisor operand, used for divide-by-zero detection.
- `z_out` out 64: {ZHI, ZLO}.
- `flag_c`, `flag_z`, `flag_n` out 1 each: carry, zero, and negative flags of the last capture.
- `div_by_zero` out 1: sticky divide-by-zero error.
- `busy` out 1: high in SETTLE.
- `done` out 1: one-cycle pulse, high in DONE.

## Operation
- States: IDLE, SETTLE, DONE. All outputs registered.
- IDLE/DONE with `start`=1: latch `op_class`; load 4-bit `cnt` = N−1, where N is the class's cycle parameter; go to SETTLE.
- DONE with `start`=0: go to IDLE. DONE lasts exactly one cycle.
- SETTLE with `cnt`≠0: decrement `cnt`. `start` is ignored; there is no queueing.
- SETTLE with `cnt`=0: capture, then go to DONE.
- Capture uses the latched class, never the live `op_class`:
  - logic: `z_out`={32'b0, `logic_result`}; C=`logic_carry`; Z=`logic_zero`; N=`logic_result`[31].
  - add/sub: `z_out`={32'b0, `addsub_result`}; C=`addsub_carry`; Z=`addsub_zero`; N=`addsub_result`[31].
  - mul: `z_out`=`mul_product`; C=0; Z=(`mul_product`==0); N=`mul_product`[63].
  - div: `z_out`={`div_remainder`, `div_quotient`}; C=0; Z=(`div_quotient`==0); N=`div_quotient`[31]. If `div_b`==0, set `div_by_zero`=1; capture proceeds unchanged.
- `div_by_zero` is sticky and is cleared only by `clear`.
- `z_out` and the flags hold their values between captures.
- Upstream must hold operands and ALU inputs stable from the accept edge through the capture edge. The stage does not register ALU inputs.

## Timing
- Reset (`clear`=1 at an edge): state IDLE, `z_out`=0, all flags 0, `div_by_zero`=0, `busy`=0, `done`=0, `cnt`=0. `clear` overrides `start` and any in-flight capture; no capture occurs at that edge.
- Accept at edge E0 → `busy`=1 after E0 → capture at edge E0+N → `done`=1 and new `z_out`/flags visible in the cycle after E0+N.
- Start-to-done latency is N edges.
- N=1: SETTLE lasts one cycle; capture at E0+1.
- Back-to-back: `start`=1 during DONE is accepted at that edge. `done` drops and `busy` rises, and the next result arrives N edges later. No idle bubble is required.
- `start` held high through SETTLE has no effect. It is re-sampled only in DONE/IDLE.
- `clear` asserted mid-SETTLE: returns to IDLE at that edge; `z_out` is zeroed; no `done` pulse.

## Test plan
- Reset: assert `clear` 2 cycles with random inputs → `z_out`=0, flags=0, `busy`=0, `done`=0, `div_by_zero`=0.
- Add/sub: `addsub_result`=0, carry=1, zero=1, start at E0 → `done` after E0+1; `z_out`=0, C=1, Z=1, N=0.
- Mul (`MUL_CYCLES`=4): `mul_product`=0xFFFFFFFF_FFFFFFEB (−3×7) → `busy` for 4 cycles, `done` after E0+4; `z_out`=0xFFFFFFFF_FFFFFFEB, N=1, Z=0. Changing `op_class` mid-SETTLE has no effect.
- Div: quotient 14, remainder 2 (100/7), `div_b`=7 → `z_out`=0x00000002_0000000E, `div_by_zero`=0. Repeat with `div_b`=0 → `div_by_zero`=1, and it stays 1 across a following logic op.
- Handshake: `start` pulsed during SETTLE → ignored, single `done`. `start`=1 in the DONE cycle → second op accepted; two `done` pulses N2+1 cycles apart.
- `clear` at the second SETTLE cycle of a div → IDLE next cycle, `z_out`=0, no `done` pulse.
